// File: rtl/io_in_conditioner.sv
// ----------------------------------------------------------------------------
// io_in_conditioner
// Input stage for the decoder: brings the asynchronous pad bus into the
// wb_clk_i domain through a two-flop synchronizer, then debounces it. Each
// settled code that differs from the last committed one is presented on a
// valid/ready handshake. A sticky overrun flag reports codes that were
// replaced before the decoder took them.
// ----------------------------------------------------------------------------
module io_in_conditioner #(
    parameter int WIDTH           = 7,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] code_o,
    output logic             code_valid_o,
    input  logic             code_ready_i,
    output logic             stable_o,
    output logic             overrun_o,
    input  logic             clear_overrun_i
);

    typedef enum logic [0:0] {
        ST_TRACK   = 1'b0,
        ST_SETTLED = 1'b1
    } state_e;

    // Terminal debounce count; the counter saturates here and never wraps.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronizer flops (nothing but wiring between them).
    logic [WIDTH-1:0] sync1_d, sync1_q;
    logic [WIDTH-1:0] sync2_d, sync2_q;

    // Debounce state.
    state_e           state_d, state_q;
    logic [WIDTH-1:0] cand_d, cand_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Presented code and status.
    logic [WIDTH-1:0] code_d, code_q;
    logic             valid_d, valid_q;
    logic             stable_d, stable_q;
    logic             overrun_d, overrun_q;

    // Internal event strobes.
    logic             commit_s;
    logic             accept_s;
    logic             overrun_set_s;

    // Synchronizer data path: straight wires into the two-stage chain.
    always_comb begin
        sync1_d = io_in;
        sync2_d = sync1_q;
    end

    // Two-flop synchronizer chain for the asynchronous pad bus.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Debounce FSM next-state: track candidate changes, settle after a full run.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        commit_s = 1'b0;
        case (state_q)
            ST_TRACK: begin
                if (sync2_q != cand_q) begin
                    // New candidate: restart the run length.
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    // Run complete. A glitch that came back to the committed
                    // code settles silently without a new presentation.
                    state_d  = ST_SETTLED;
                    cnt_d    = CNT_MAX;
                    commit_s = (cand_q != code_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLED: begin
                if (sync2_q != cand_q) begin
                    state_d = ST_TRACK;
                    cand_d  = sync2_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CNT_MAX;
                end
            end
            default: begin
                // Unreachable encoding: recover into tracking from scratch.
                state_d = ST_TRACK;
                cand_d  = sync2_q;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake and overrun next-state: commit beats accept, set beats clear.
    always_comb begin
        accept_s      = valid_q & code_ready_i;
        overrun_set_s = commit_s & valid_q & ~code_ready_i;

        if (commit_s) begin
            code_d  = cand_q;
            valid_d = 1'b1;
        end else if (accept_s) begin
            code_d  = code_q;
            valid_d = 1'b0;
        end else begin
            code_d  = code_q;
            valid_d = valid_q;
        end

        if (overrun_set_s) begin
            overrun_d = 1'b1;
        end else if (clear_overrun_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        stable_d = (state_d == ST_SETTLED);
    end

    // State, candidate, counter and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_TRACK;
            cand_q    <= '0;
            cnt_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            stable_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            stable_q  <= stable_d;
            overrun_q <= overrun_d;
        end
    end

    assign code_o       = code_q;
    assign code_valid_o = valid_q;
    assign stable_o     = stable_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_io_in_conditioner.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for io_in_conditioner (DEBOUNCE_CYCLES=16).
// A change applied just after edge E0-1 is sampled at E0; the code is
// committed on edge E0+18, so 18 steps show valid low and the 19th valid high.
// ----------------------------------------------------------------------------
module tb_io_in_conditioner;

    logic       clk;
    logic       rst;
    logic [6:0] io_in;
    logic [6:0] code_o;
    logic       code_valid_o;
    logic       code_ready_i;
    logic       stable_o;
    logic       overrun_o;
    logic       clear_overrun_i;

    int chk_cnt;
    int err_cnt;

    io_in_conditioner #(
        .WIDTH          (7),
        .DEBOUNCE_CYCLES(16),
        .CNT_W          (8)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .io_in          (io_in),
        .code_o         (code_o),
        .code_valid_o   (code_valid_o),
        .code_ready_i   (code_ready_i),
        .stable_o       (stable_o),
        .overrun_o      (overrun_o),
        .clear_overrun_i(clear_overrun_i)
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        chk_cnt         = 0;
        err_cnt         = 0;
        rst             = 1'b1;
        io_in           = 7'b0000000;
        code_ready_i    = 1'b0;
        clear_overrun_i = 1'b0;

        // 1: reset, input held at zero; settles 16 edges after reset, no commit.
        step(2);
        rst = 1'b0;
        check_eq("rst_code",    {25'd0, code_o},       32'h0);
        check_eq("rst_valid",   {31'd0, code_valid_o}, 32'h0);
        check_eq("rst_stable",  {31'd0, stable_o},     32'h0);
        check_eq("rst_overrun", {31'd0, overrun_o},    32'h0);
        step(15);
        check_eq("t1_stable_lo", {31'd0, stable_o}, 32'h0);
        step(1);
        check_eq("t1_stable_hi", {31'd0, stable_o}, 32'h1);
        step(24);
        check_eq("t1_valid", {31'd0, code_valid_o}, 32'h0);
        check_eq("t1_code",  {25'd0, code_o},       32'h0);

        // 2: clean change to 1100111 with ready high.
        code_ready_i = 1'b1;
        io_in        = 7'b1100111;
        step(18);
        check_eq("t2_valid_early", {31'd0, code_valid_o}, 32'h0);
        check_eq("t2_stable_early", {31'd0, stable_o},    32'h0);
        step(1);
        check_eq("t2_valid", {31'd0, code_valid_o}, 32'h1);
        check_eq("t2_code",  {25'd0, code_o},       32'h67);
        check_eq("t2_stable", {31'd0, stable_o},    32'h1);
        step(1);
        check_eq("t2_accepted", {31'd0, code_valid_o}, 32'h0);
        step(30);
        check_eq("t2_no_repeat", {31'd0, code_valid_o}, 32'h0);
        check_eq("t2_code_hold", {25'd0, code_o},       32'h67);

        // 3: toggle every 5 cycles for 100 cycles, then hold 1100110.
        for (int seg = 0; seg < 20; seg++) begin
            io_in = (seg % 2 == 0) ? 7'b1100110 : 7'b1100111;
            for (int c = 0; c < 5; c++) begin
                step(1);
                check_eq("t3_toggle_valid", {31'd0, code_valid_o}, 32'h0);
                if (seg > 0 || c >= 2) begin
                    check_eq("t3_toggle_stable", {31'd0, stable_o}, 32'h0);
                end
            end
        end
        io_in = 7'b1100110;
        step(18);
        check_eq("t3_valid_early", {31'd0, code_valid_o}, 32'h0);
        step(1);
        check_eq("t3_valid", {31'd0, code_valid_o}, 32'h1);
        check_eq("t3_code",  {25'd0, code_o},       32'h66);
        step(1);
        check_eq("t3_accepted", {31'd0, code_valid_o}, 32'h0);

        // 4: commit 1100111, then a 3-cycle glitch to 0000001 and back.
        io_in = 7'b1100111;
        step(19);
        check_eq("t4_commit_valid", {31'd0, code_valid_o}, 32'h1);
        check_eq("t4_commit_code",  {25'd0, code_o},       32'h67);
        step(1);
        check_eq("t4_accepted", {31'd0, code_valid_o}, 32'h0);
        io_in = 7'b0000001;
        step(3);
        check_eq("t4_stable_drop", {31'd0, stable_o}, 32'h0);
        io_in = 7'b1100111;
        for (int c = 0; c < 18; c++) begin
            step(1);
            check_eq("t4_glitch_valid", {31'd0, code_valid_o}, 32'h0);
        end
        check_eq("t4_stable_lo", {31'd0, stable_o}, 32'h0);
        step(1);
        check_eq("t4_stable_hi", {31'd0, stable_o},     32'h1);
        check_eq("t4_no_valid",  {31'd0, code_valid_o}, 32'h0);
        check_eq("t4_code_kept", {25'd0, code_o},       32'h67);

        // 5a: ready low, two commits in a row -> overwrite and overrun.
        code_ready_i = 1'b0;
        io_in        = 7'b1100110;
        step(19);
        check_eq("t5_first_valid", {31'd0, code_valid_o}, 32'h1);
        check_eq("t5_first_code",  {25'd0, code_o},       32'h66);
        check_eq("t5_first_ovr",   {31'd0, overrun_o},    32'h0);
        step(5);
        check_eq("t5_hold_valid", {31'd0, code_valid_o}, 32'h1);
        check_eq("t5_hold_code",  {25'd0, code_o},       32'h66);
        io_in = 7'b0011000;
        step(18);
        check_eq("t5_pre_code", {25'd0, code_o},    32'h66);
        check_eq("t5_pre_ovr",  {31'd0, overrun_o}, 32'h0);
        step(1);
        check_eq("t5_over_code",  {25'd0, code_o},       32'h18);
        check_eq("t5_over_valid", {31'd0, code_valid_o}, 32'h1);
        check_eq("t5_over_ovr",   {31'd0, overrun_o},    32'h1);
        step(3);
        check_eq("t5_ovr_sticky", {31'd0, overrun_o}, 32'h1);
        clear_overrun_i = 1'b1;
        step(1);
        clear_overrun_i = 1'b0;
        check_eq("t5_ovr_clear",   {31'd0, overrun_o},    32'h0);
        check_eq("t5_clear_valid", {31'd0, code_valid_o}, 32'h1);
        step(3);
        check_eq("t5_ovr_stays_clear", {31'd0, overrun_o}, 32'h0);
        code_ready_i = 1'b1;
        step(1);
        check_eq("t5_accept_valid", {31'd0, code_valid_o}, 32'h0);
        check_eq("t5_accept_code",  {25'd0, code_o},       32'h18);
        code_ready_i = 1'b0;

        // 5b: clear and a new overrun on the same edge -> set wins.
        io_in = 7'b1010101;
        step(19);
        check_eq("t5b_valid", {31'd0, code_valid_o}, 32'h1);
        check_eq("t5b_code",  {25'd0, code_o},       32'h55);
        io_in = 7'b0101010;
        step(18);
        clear_overrun_i = 1'b1;
        step(1);
        clear_overrun_i = 1'b0;
        check_eq("t5b_set_wins", {31'd0, overrun_o}, 32'h1);
        check_eq("t5b_code2",    {25'd0, code_o},    32'h2a);
        step(1);
        check_eq("t5b_sticky", {31'd0, overrun_o}, 32'h1);

        // 5c: accept and commit on the same edge -> valid stays, no overrun.
        clear_overrun_i = 1'b1;
        step(1);
        clear_overrun_i = 1'b0;
        check_eq("t5c_ovr_clear", {31'd0, overrun_o}, 32'h0);
        io_in = 7'b1111000;
        step(18);
        code_ready_i = 1'b1;
        step(1);
        check_eq("t5c_valid", {31'd0, code_valid_o}, 32'h1);
        check_eq("t5c_code",  {25'd0, code_o},       32'h78);
        check_eq("t5c_ovr",   {31'd0, overrun_o},    32'h0);
        step(1);
        check_eq("t5c_accepted", {31'd0, code_valid_o}, 32'h0);
        code_ready_i = 1'b0;

        // 6: reset mid-track (cnt=7) with a pending code, then re-debounce.
        io_in = 7'b0000111;
        step(19);
        check_eq("t6_pending_valid", {31'd0, code_valid_o}, 32'h1);
        check_eq("t6_pending_code",  {25'd0, code_o},       32'h07);
        io_in = 7'b0001111;
        step(10);
        check_eq("t6_tracking", {31'd0, stable_o}, 32'h0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_eq("t6_rst_code",   {25'd0, code_o},       32'h0);
        check_eq("t6_rst_valid",  {31'd0, code_valid_o}, 32'h0);
        check_eq("t6_rst_stable", {31'd0, stable_o},     32'h0);
        check_eq("t6_rst_ovr",    {31'd0, overrun_o},    32'h0);
        step(18);
        check_eq("t6_valid_early", {31'd0, code_valid_o}, 32'h0);
        step(1);
        check_eq("t6_valid",  {31'd0, code_valid_o}, 32'h1);
        check_eq("t6_code",   {25'd0, code_o},       32'h0f);
        check_eq("t6_stable", {31'd0, stable_o},     32'h1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
